// File: rtl/length_counter_timer.sv
// Length counter and period timer for a pulse/noise style audio channel.
// The timer emits a sequencer step pulse; the length counter gates the channel.
module length_counter_timer (
   input  logic        clk,
   input  logic        reset,
   input  logic [10:0] period,
   output logic        seq_tick,
   input  logic        length_tick,
   input  logic        halt,
   input  logic        enable,
   input  logic        load,
   input  logic [4:0]  length_index,
   output logic [7:0]  length_count,
   output logic        length_active
);

   logic [10:0] tcnt;
   logic [7:0]  tableValue;
   logic        decEn;

   // Period is only sampled at reload, so a running count is never disturbed.
   always_ff @(posedge clk) begin
      if (reset) begin
         tcnt     <= '0;
         seq_tick <= 1'b0;
      end else if (tcnt == 11'd0) begin
         tcnt     <= period;
         seq_tick <= 1'b1;
      end else begin
         tcnt     <= tcnt - 11'd1;
         seq_tick <= 1'b0;
      end
   end

   always_comb begin
      tableValue = 8'd0;
      unique case (length_index)
         5'd0:  tableValue = 8'd10;
         5'd1:  tableValue = 8'd254;
         5'd2:  tableValue = 8'd20;
         5'd3:  tableValue = 8'd2;
         5'd4:  tableValue = 8'd40;
         5'd5:  tableValue = 8'd4;
         5'd6:  tableValue = 8'd80;
         5'd7:  tableValue = 8'd6;
         5'd8:  tableValue = 8'd160;
         5'd9:  tableValue = 8'd8;
         5'd10: tableValue = 8'd60;
         5'd11: tableValue = 8'd10;
         5'd12: tableValue = 8'd14;
         5'd13: tableValue = 8'd12;
         5'd14: tableValue = 8'd26;
         5'd15: tableValue = 8'd14;
         5'd16: tableValue = 8'd12;
         5'd17: tableValue = 8'd16;
         5'd18: tableValue = 8'd24;
         5'd19: tableValue = 8'd18;
         5'd20: tableValue = 8'd48;
         5'd21: tableValue = 8'd20;
         5'd22: tableValue = 8'd96;
         5'd23: tableValue = 8'd22;
         5'd24: tableValue = 8'd192;
         5'd25: tableValue = 8'd24;
         5'd26: tableValue = 8'd72;
         5'd27: tableValue = 8'd26;
         5'd28: tableValue = 8'd16;
         5'd29: tableValue = 8'd28;
         5'd30: tableValue = 8'd32;
         5'd31: tableValue = 8'd30;
      endcase
   end

   assign decEn = length_tick && !halt && (length_count != 8'd0);

   // Disable beats load, load beats decrement; zero never wraps.
   always_ff @(posedge clk) begin
      if (reset) begin
         length_count <= '0;
      end else begin
         priority case (1'b1)
            !enable: length_count <= 8'd0;
            load:    length_count <= tableValue;
            decEn:   length_count <= length_count - 8'd1;
            default: length_count <= length_count;
         endcase
      end
   end

   assign length_active = (length_count != 8'd0);

endmodule

// File: tb/tb_length_counter_timer.sv
// Scoreboard bench for length_counter_timer against a cycle-indexed
// model: pulse times as absolute edge numbers, length count as an integer.
module tb_length_counter_timer;

   logic        clk;
   logic        reset;
   logic [10:0] period;
   logic        seq_tick;
   logic        length_tick;
   logic        halt;
   logic        enable;
   logic        load;
   logic [4:0]  length_index;
   logic [7:0]  length_count;
   logic        length_active;

   length_counter_timer dut (
      .clk(clk),
      .reset(reset),
      .period(period),
      .seq_tick(seq_tick),
      .length_tick(length_tick),
      .halt(halt),
      .enable(enable),
      .load(load),
      .length_index(length_index),
      .length_count(length_count),
      .length_active(length_active)
   );

   typedef struct {
      int   edgeNo;
      logic seq;
      int   cnt;
   } exp_t;

   exp_t expQ[$];
   int   total = 0;
   int   bad = 0;
   bit   stimDone = 0;

   int lenTable [32] = '{10,254,20,2,40,4,80,6,160,8,60,10,14,12,26,14,
                         12,16,24,18,48,20,96,22,192,24,72,26,16,28,32,30};

   int edgeNo = 0;
   int nextPulse = 1;
   int mCount = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Model one rising edge from the inputs currently applied, then let it happen.
   task automatic cyc();
      exp_t e;
      edgeNo++;
      e.edgeNo = edgeNo;
      if (reset) begin
         e.seq = 1'b0;
         mCount = 0;
         nextPulse = edgeNo + 1;
      end else begin
         e.seq = (edgeNo == nextPulse);
         if (e.seq) nextPulse = edgeNo + int'(period) + 1;
         if (!enable) mCount = 0;
         else if (load) mCount = lenTable[length_index];
         else if (length_tick && !halt && mCount > 0) mCount = mCount - 1;
      end
      e.cnt = mCount;
      expQ.push_back(e);
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc();
   endtask

   // Monitor: outputs are valid every cycle, sampled 1 ns after the edge.
   always @(posedge clk) begin
      exp_t e;
      #1;
      if (expQ.size() != 0) begin
         e = expQ.pop_front();
         total++;
         if (seq_tick !== e.seq) begin
            bad++;
            $display("FAIL seq_tick edge=%0d got=%0b want=%0b",
                     e.edgeNo, seq_tick, e.seq);
         end
         total++;
         if (length_count !== 8'(e.cnt)) begin
            bad++;
            $display("FAIL length_count edge=%0d got=%0d want=%0d",
                     e.edgeNo, length_count, e.cnt);
         end
         total++;
         if (length_active !== (e.cnt != 0)) begin
            bad++;
            $display("FAIL length_active edge=%0d got=%0b want=%0b",
                     e.edgeNo, length_active, (e.cnt != 0));
         end
      end
   end

   initial begin
      reset = 1'b1;
      period = 11'd3;
      length_tick = 1'b0;
      halt = 1'b0;
      enable = 1'b0;
      load = 1'b0;
      length_index = 5'd0;
      idle(3);

      // period=3 from release: pulses every 4 cycles
      reset = 1'b0;
      idle(14);

      // period=0 then 2
      period = 11'd0;
      idle(8);
      period = 11'd2;
      idle(12);

      // 254 countdown, then extra ticks at zero
      enable = 1'b1;
      load = 1'b1;
      length_index = 5'd1;
      cyc();
      load = 1'b0;
      length_tick = 1'b1;
      idle(258);
      length_tick = 1'b0;

      // halt freezes, load while halted
      load = 1'b1;
      length_index = 5'd3;
      cyc();
      load = 1'b0;
      halt = 1'b1;
      for (int i = 0; i < 5; i++) begin
         length_tick = 1'b1; cyc();
         length_tick = 1'b0; cyc();
      end
      load = 1'b1;
      length_index = 5'd5;
      cyc();
      load = 1'b0;
      halt = 1'b0;
      length_tick = 1'b1;
      idle(6);

      // load vs tick, then disable, then load while disabled
      load = 1'b1;
      length_index = 5'd8;
      cyc();
      load = 1'b0;
      length_tick = 1'b0;
      cyc();
      enable = 1'b0;
      cyc();
      load = 1'b1;
      cyc();
      load = 1'b0;
      cyc();

      // full table sweep
      enable = 1'b1;
      for (int i = 0; i < 32; i++) begin
         load = 1'b1;
         length_index = 5'(i);
         cyc();
         load = 1'b0;
         cyc();
      end

      // reset overrides load and tick
      load = 1'b1;
      length_index = 5'd2;
      period = 11'd5;
      cyc();
      reset = 1'b1;
      length_tick = 1'b1;
      cyc();
      reset = 1'b0;
      load = 1'b0;
      length_tick = 1'b0;
      idle(4);

      // longest period
      period = 11'd2047;
      idle(4200);

      // random mix
      for (int i = 0; i < 600; i++) begin
         reset = ($urandom_range(0, 49) == 0);
         if ($urandom_range(0, 19) == 0)
            period = ($urandom_range(0, 9) == 0) ? 11'd2047
                                                 : 11'($urandom_range(0, 12));
         length_tick = $urandom_range(0, 1) == 1;
         halt = ($urandom_range(0, 7) == 0);
         enable = ($urandom_range(0, 15) != 0);
         load = ($urandom_range(0, 9) == 0);
         length_index = 5'($urandom_range(0, 31));
         cyc();
      end
      reset = 1'b0;
      load = 1'b0;
      idle(2);
      stimDone = 1'b1;
   end

   initial begin
      wait (stimDone);
      for (int i = 0; i < 10 && expQ.size() != 0; i++) @(negedge clk);
      total++;
      if (expQ.size() != 0) begin
         bad++;
         $display("FAIL drain left=%0d want=0", expQ.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout got=running want=done");
      bad++;
      $display("test done: total=%0d bad=%0d", total, bad);
      $fatal(1, "timeout");
   end

endmodule
